// File: rtl/mac_seq_ctrl.sv
// MAC array sequencer: kernel load, gap, activation execute with output-FIFO backpressure, drain, done.
// Optional stall cycle counter is built only when MAC_SEQ_STALL_CNT_EN is defined.
module mac_seq_ctrl #(
  parameter int col     = 8,
  parameter int row     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 8,
  parameter int gap     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode_2b_in,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] a_base,
  input  logic [len_bw-1:0]  act_len,
  input  logic               ofifo_full,
  output logic               mem_cen,
  output logic [addr_bw-1:0] mem_addr,
  output logic [1:0]         inst_w,
  output logic               mode_2b,
  output logic               busy,
  output logic               done,
  output logic [15:0]        stall_cnt
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GAP   = 3'd2,
    S_EXEC  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [addr_bw-1:0] w_base_q;
  logic [addr_bw-1:0] a_base_q;
  logic [len_bw-1:0]  act_len_q;
  logic               mode_2b_q;
  logic               mem_cen_q;
  logic [addr_bw-1:0] mem_addr_q;
  logic [1:0]         inst_w_q;
  logic               busy_q;
  logic               done_q;

  logic [CNT_W-1:0]   n_load_s;
  logic               accept_s;
  logic               stall_s;

  assign n_load_s = mode_2b_q ? CNT_W'(2 * col) : CNT_W'(col);
  assign accept_s = (state_q == S_IDLE) && start;
  assign stall_s  = (state_q == S_EXEC) && ofifo_full;

  // cnt_q counts reads already issued in LOAD/EXEC, and elapsed cycles in GAP/DRAIN
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      w_base_q   <= '0;
      a_base_q   <= '0;
      act_len_q  <= '0;
      mode_2b_q  <= 1'b0;
      mem_cen_q  <= 1'b1;
      mem_addr_q <= '0;
      inst_w_q   <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inst_w_q <= {(state_q == S_EXEC) && !mem_cen_q, (state_q == S_LOAD) && !mem_cen_q};
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= S_LOAD;
            w_base_q   <= w_base;
            a_base_q   <= a_base;
            act_len_q  <= act_len;
            mode_2b_q  <= mode_2b_in;
            mem_cen_q  <= 1'b0;
            mem_addr_q <= w_base;
            cnt_q      <= CNT_W'(1);
            busy_q     <= 1'b1;
          end else begin
            mem_cen_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cnt_q == n_load_s) begin
            state_q   <= S_GAP;
            mem_cen_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            mem_cen_q  <= 1'b0;
            mem_addr_q <= w_base_q + addr_bw'(cnt_q);
            cnt_q      <= cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == CNT_W'(gap - 1)) begin
            if (act_len_q == '0) begin
              state_q   <= S_DRAIN;
              mem_cen_q <= 1'b1;
              cnt_q     <= '0;
            end else begin
              state_q    <= S_EXEC;
              mem_cen_q  <= 1'b0;
              mem_addr_q <= a_base_q;
              cnt_q      <= CNT_W'(1);
            end
          end else begin
            mem_cen_q <= 1'b1;
            cnt_q     <= cnt_q + CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (ofifo_full) begin
            mem_cen_q <= 1'b1;
          end else if (cnt_q == CNT_W'(act_len_q)) begin
            state_q   <= S_DRAIN;
            mem_cen_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            mem_cen_q  <= 1'b0;
            mem_addr_q <= a_base_q + addr_bw'(cnt_q);
            cnt_q      <= cnt_q + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          mem_cen_q <= 1'b1;
          if (cnt_q == CNT_W'(row + col - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          mem_cen_q <= 1'b1;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          cnt_q     <= '0;
        end
        default: begin
          state_q   <= S_IDLE;
          mem_cen_q <= 1'b1;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          cnt_q     <= '0;
        end
      endcase
    end
  end

`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of EXEC backpressure cycles, cleared when a job is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'h0000;
    end else if (accept_s) begin
      stall_q <= 16'h0000;
    end else if (stall_s && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cnt = stall_q;
`else
  logic unused_s;
  assign unused_s  = accept_s ^ stall_s;
  assign stall_cnt = 16'h0000;
`endif

  assign mem_cen  = mem_cen_q;
  assign mem_addr = mem_addr_q;
  assign inst_w   = inst_w_q;
  assign mode_2b  = mode_2b_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed jobs plus randomized jobs/backpressure
// against a per-job expected-trace model built from the sequencing rules.
module tb_mac_seq_ctrl;

  localparam int COL = 8;
  localparam int ROW = 8;
  localparam int AW  = 11;
  localparam int LW  = 8;
  localparam int GAP = 8;
`ifdef MAC_SEQ_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode_2b_in;
  logic [AW-1:0] w_base;
  logic [AW-1:0] a_base;
  logic [LW-1:0] act_len;
  logic          ofifo_full;
  logic          mem_cen;
  logic [AW-1:0] mem_addr;
  logic [1:0]    inst_w;
  logic          mode_2b;
  logic          busy;
  logic          done;
  logic [15:0]   stall_cnt;

  mac_seq_ctrl #(.col(COL), .row(ROW), .addr_bw(AW), .len_bw(LW), .gap(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_2b_in(mode_2b_in),
    .w_base(w_base), .a_base(a_base), .act_len(act_len), .ofifo_full(ofifo_full),
    .mem_cen(mem_cen), .mem_addr(mem_addr), .inst_w(inst_w), .mode_2b(mode_2b),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          cen;
    logic [AW-1:0] addr;
    logic [1:0]    inst;
    logic          busy;
    logic          done;
    logic          mode;
    logic [15:0]   stall;
  } exp_t;

  exp_t          tr[$];
  logic          full_pat[512];
  logic [AW-1:0] m_addr;
  logic          m_mode;
  logic [15:0]   m_stall;
  logic [1:0]    m_prev;
  int            checks = 0;
  int            errors = 0;
  int            cur_t;
  int            dut_done_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, ex);
    end
  endtask

  // one expected cycle; rd=1 means an SRAM read of address a of kind (01 load / 10 exec)
  function automatic void push(input logic rd, input logic [1:0] kind, input logic [AW-1:0] a,
                               input logic dn, input logic bsy);
    exp_t e;
    if (rd) m_addr = a;
    e.cen   = !rd;
    e.addr  = m_addr;
    e.inst  = m_prev;
    e.busy  = bsy;
    e.done  = dn;
    e.mode  = m_mode;
    e.stall = m_stall;
    tr.push_back(e);
    m_prev = rd ? kind : 2'b00;
  endfunction

  function automatic void build(input logic mode, input logic [AW-1:0] wb,
                                input logic [AW-1:0] ab, input int len);
    int n;
    int j;
    tr.delete();
    m_mode  = mode;
    m_stall = 16'h0000;
    m_prev  = 2'b00;
    n = mode ? 2 * COL : COL;
    for (int k = 0; k < n; k++) push(1'b1, 2'b01, AW'(wb + k), 1'b0, 1'b1);
    for (int g = 0; g < GAP; g++) push(1'b0, 2'b00, '0, 1'b0, 1'b1);
    if (len > 0) begin
      push(1'b1, 2'b10, ab, 1'b0, 1'b1);
      j = 1;
      for (int guard = 0; guard < 600; guard++) begin
        if (full_pat[tr.size() - 1]) begin
          if (STALL_EN && m_stall != 16'hFFFF) m_stall = m_stall + 16'h0001;
          push(1'b0, 2'b00, '0, 1'b0, 1'b1);
        end else if (j < len) begin
          push(1'b1, 2'b10, AW'(ab + j), 1'b0, 1'b1);
          j++;
        end else begin
          break;
        end
      end
    end
    for (int d = 0; d < ROW + COL; d++) push(1'b0, 2'b00, '0, 1'b0, 1'b1);
    push(1'b0, 2'b00, '0, 1'b1, 1'b1);
    push(1'b0, 2'b00, '0, 1'b0, 1'b0);
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cen"},   32'(mem_cen),   32'd1);
    chk({tag, "_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_inst"},  32'(inst_w),    32'd0);
    chk({tag, "_mode"},  32'(mode_2b),   32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
    chk({tag, "_stall"}, 32'(stall_cnt), 32'd0);
  endtask

  task automatic clr_full();
    for (int i = 0; i < 512; i++) full_pat[i] = 1'b0;
  endtask

  task automatic run_job(input logic mode, input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                         input int len, input int abort_at);
    build(mode, wb, ab, len);
    mode_2b_in = mode;
    w_base     = wb;
    a_base     = ab;
    act_len    = LW'(len);
    start      = 1'b1;
    ofifo_full = 1'($urandom);
    dut_done_t = -1;
    @(posedge clk); #1;
    for (int t = 0; t < tr.size(); t++) begin
      cur_t      = t;
      ofifo_full = full_pat[t];
      start      = (t < tr.size() - 1) ? 1'($urandom) : 1'b0;
      mode_2b_in = 1'($urandom);
      w_base     = AW'($urandom);
      a_base     = AW'($urandom);
      act_len    = LW'($urandom);
      @(negedge clk);
      if (done === 1'b1 && dut_done_t < 0) dut_done_t = t;
      chk("mem_cen",   32'(mem_cen),   32'(tr[t].cen));
      chk("mem_addr",  32'(mem_addr),  32'(tr[t].addr));
      chk("inst_w",    32'(inst_w),    32'(tr[t].inst));
      chk("busy",      32'(busy),      32'(tr[t].busy));
      chk("done",      32'(done),      32'(tr[t].done));
      chk("mode_2b",   32'(mode_2b),   32'(tr[t].mode));
      chk("stall_cnt", 32'(stall_cnt), 32'(tr[t].stall));
      if (t == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_reset_vals("abort");
        m_addr  = '0;
        m_mode  = 1'b0;
        m_stall = 16'h0000;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    mode_2b_in = 1'b0;
    w_base     = '0;
    a_base     = '0;
    act_len    = '0;
    ofifo_full = 1'b0;
    m_addr     = '0;
    m_mode     = 1'b0;
    m_stall    = 16'h0000;
    cur_t      = -1;
    clr_full();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // vanilla job and its start-to-done latency
    run_job(1'b0, 11'h010, 11'h100, 4, -1);
    chk("latency", 32'(dut_done_t), 32'd36);

    // 2b job
    run_job(1'b1, AW'($urandom), AW'($urandom), 2, -1);

    // backpressure for 3 cycles starting at the 2nd execute read
    clr_full();
    for (int i = 17; i < 20; i++) full_pat[i] = 1'b1;
    run_job(1'b0, 11'h010, 11'h100, 4, -1);
    chk("stall_total", 32'(stall_cnt), STALL_EN ? 32'd3 : 32'd0);
    clr_full();

    // no activations
    run_job(1'b0, AW'($urandom), AW'($urandom), 0, -1);

    // abort in EXEC, then a normal job with start pulses during busy
    run_job(1'b0, 11'h020, 11'h200, 6, COL + GAP + 1);
    run_job(1'b0, 11'h030, 11'h300, 3, -1);

    // weight address wrap
    run_job(1'b0, 11'h7FC, 11'h7FE, 5, -1);

    // randomized jobs with random backpressure in every state
    for (int r = 0; r < 6; r++) begin
      clr_full();
      for (int i = 0; i < 200; i++) full_pat[i] = ($urandom_range(0, 3) == 0);
      run_job(1'($urandom), AW'($urandom), AW'($urandom), $urandom_range(0, 12), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- col, 8: PE columns.
- row, 8: PE rows.
- addr_bw, 11: SRAM address width.
- len_bw, 8: activation-count width.
- gap, 8: idle cycles between load and execute.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- start, in, 1: job request.
- mode_2b_in, in, 1: 1 = 2b activations with 2 weights per PE; 0 = 4b vanilla.
- w_base, in, addr_bw: weight SRAM base address.
- a_base, in, addr_bw: activation SRAM base address.
- act_len, in, len_bw: number of activation vectors.
- ofifo_full, in, 1: output FIFO full (backpressure).
- mem_cen, out, 1: SRAM chip enable, active low.
- mem_addr, out, addr_bw: SRAM read address.
- inst_w, out, 2: array instruction; [1] execute, [0] kernel load.
- mode_2b, out, 1: latched mode to the array.
- busy, out, 1: job in progress.
- done, out, 1: one-cycle completion pulse.
- stall_cnt, out, 16: stall cycle counter.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, GAP, EXEC, DRAIN, DONE.

REQ-004 IDLE SHALL go to LOAD when start=1. On that edge it SHALL latch mode_2b_in, w_base, a_base and act_len.

REQ-005 In IDLE, start=0 SHALL hold IDLE. While busy, start SHALL be ignored.

REQ-006 Mid-job changes to mode_2b_in, w_base, a_base or act_len SHALL have no effect.

REQ-007 LOAD SHALL issue N = col reads (mode_2b=0) or N = 2*col reads (mode_2b=1).
- Read k (k = 0..N-1) drives mem_cen=0 and mem_addr = w_base+k.
- In 2b mode, reads 0..col-1 fill wgt0 and reads col..2col-1 fill wgt1.

REQ-008 inst_w SHALL be registered and aligned to SRAM read data.
- inst_w=01 exactly one cycle after each LOAD read.
- inst_w=10 exactly one cycle after each EXEC read.
- inst_w=00 otherwise.

REQ-009 GAP SHALL last exactly gap cycles with mem_cen=1, then go to EXEC.

REQ-010 EXEC SHALL issue act_len reads at mem_addr = a_base+j (j = 0..act_len-1), then go to DRAIN.

REQ-011 If act_len=0, GAP SHALL go directly to DRAIN with no execute cycles.

REQ-012 In EXEC with ofifo_full=1, the block SHALL stall:
- mem_cen=1.
- The read counter holds.
- inst_w=00 on the following cycle.
- Reads resume at the same j when ofifo_full falls.

REQ-013 ofifo_full SHALL be ignored in all states other than EXEC.

REQ-014 DRAIN SHALL last exactly row+col cycles with inst_w=00, then go to DONE.

REQ-015 DONE SHALL last one cycle with done=1, then return to IDLE. A start sampled in DONE SHALL be ignored.

REQ-016 busy SHALL be 1 in every state except IDLE.

REQ-017 mem_addr SHALL wrap modulo 2^addr_bw on base+offset overflow.

REQ-018 When mem_cen=1, mem_addr SHALL hold its last value.

REQ-019 mode_2b SHALL be driven from the latched value and change only on a start acceptance.

Reset
REQ-020 reset=1 at a clock edge SHALL force the following, including mid-job; no done pulse is generated on abort:
- FSM to IDLE.
- All counters to 0.
- mem_cen=1, mem_addr=0, inst_w=00, mode_2b=0, busy=0, done=0, stall_cnt=0.

REQ-021 After reset is released, the first start SHALL be accepted normally.

Configuration
REQ-022 With MAC_SEQ_STALL_CNT_EN defined, stall_cnt behaves as follows:
- It increments by 1 on every EXEC stall cycle.
- It saturates at 16'hFFFF.
- It clears on start acceptance.
- It holds its value after DONE.

REQ-023 Without MAC_SEQ_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-024 The bench SHALL cover these directed scenarios (parameters col=8, row=8, gap=8 unless stated):
- Vanilla job (mode_2b_in=0, w_base=0x010, a_base=0x100, act_len=4) -> 8 cycles inst_w=01 at addresses 0x010..0x017; 8 idle cycles; 4 cycles inst_w=10 at 0x100..0x103; 16 drain cycles; done one cycle later. Total start-to-done latency = 1+8+8+4+16+1 cycles.
- 2b job (mode_2b_in=1, act_len=2) -> 16 load reads at w_base..w_base+15; mode_2b=1 throughout; 2 execute reads.
- ofifo_full held 3 cycles during the 2nd EXEC read (act_len=4) -> addresses 0x100, 0x101 (held), then 0x102, 0x103; inst_w=00 for 3 cycles; stall_cnt=3 when MAC_SEQ_STALL_CNT_EN is defined, 0 otherwise.
- act_len=0 -> no inst_w=10 cycles; done still pulses after drain.
- Reset asserted during EXEC, then start pulsed during busy of a new job -> outputs at reset values the next cycle, no done; the second start is ignored and only one done pulse appears.
- w_base=0x7FC with col=8 -> load addresses 0x7FC..0x7FF, then 0x000..0x003.
